gate_truth_table_checker: RTL and testbench
===========================================

# gate_truth_table_checker

Sequential stimulus generator and response checker for the two-input NOT/NAND/NOR gate unit, where y0 = ~a, y1 = ~(a&b) and y2 = ~(a|b). It sits on the opposite side of that unit's interface: it drives a and b, and it receives y0..y2. On a start pulse it sweeps all four input vectors, optionally for several loops. It waits a programmable settle time per vector, compares each response against the expected truth table, and reports pass/fail, an error count, per-output failure flags and the first failing vector.

## Interface
- SETTLE_CYCLES, 2: cycles each vector is held before its response is sampled; legal range 1..15.
- LOOPS, 1: number of full 4-vector sweeps per run; legal range 1..255.
- ERR_W, 8: width of err_count.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  run request; level-sampled in IDLE only.
- a  out  1  stimulus to the gate unit (registered).
- b  out  1  stimulus to the gate unit (registered).
- y0, y1, y2  in  1 each  gate unit responses; synchronous to clk and stable by the sample edge.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at run completion.
- pass  out  1  result of the last run; 1 means no mismatches.
- err_count  out  ERR_W  number of mismatching vector samples, saturating.
- fail_vec  out  3  sticky per-output mismatch flags; bit k corresponds to yk.
- first_fail_idx  out  2  {a,b} of the first mismatching sample; 0 if there was none.

## Operation
- States:
  - IDLE → RUN on start=1.
  - RUN → FINISH at the last sample edge.
  - FINISH → IDLE unconditionally, asserting done.
- Start acceptance (edge E0, start=1 in IDLE):
  - {a,b} <= 2'b00; busy <= 1; pass <= 0.
  - err_count, fail_vec and first_fail_idx clear to 0.
  - Vector index, settle counter and loop counter are zeroed.
- Vector order {a,b}: 00, 01, 10, 11. After 11 the index wraps to 00 and the loop counter increments.
- Expected response: {y2,y1,y0} = {~(a|b), ~(a&b), ~a}, taken from the currently driven a/b.
- Sample edge: SETTLE_CYCLES edges after the edge that applied the vector. At that same edge:
  - mism = {y2,y1,y0} ^ expected.
  - fail_vec <= fail_vec | mism.
  - If mism != 0: err_count increments by 1 per vector, not per bit, and saturates at 2^ERR_W-1.
  - If mism != 0 and this is the first failure of the run, first_fail_idx <= {a,b}.
  - The next vector is applied. If this was the last sample, the state moves to FINISH and {a,b} <= 00.
- FINISH edge: busy <= 0; pass <= (err_count==0 and the final sample had no mismatch); done <= 1 for exactly one cycle; state moves to IDLE.
- Results (pass, err_count, fail_vec, first_fail_idx) hold until the next accepted start.
- start is ignored while busy=1 or in FINISH.
- start=1 in the cycle where done=1 (FSM is already in IDLE) is accepted and clears results.
- Reset asserted at any time, including mid-run:
  - All outputs go immediately to reset values: a=0, b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, first_fail_idx=0.
  - State goes to IDLE; no done pulse is produced for the aborted run.

## Timing
- Each vector is held for exactly SETTLE_CYCLES cycles.
- Last sample edge = E0 + 4·SETTLE_CYCLES·LOOPS.
- done is high in the cycle following edge E0 + 4·SETTLE_CYCLES·LOOPS + 1.
- busy is high from E0 through the FINISH edge.
- a/b change only on start acceptance, sample edges and reset. They are glitch-free registered outputs.
- Responses are sampled combinationally at the sample edge; no input synchronizers.

## Test plan
- Correct gate model, SETTLE_CYCLES=2, LOOPS=1, start pulse at E0:
  - a/b go 00,01,10,11, each held 2 cycles; samples at E0+2/4/6/8.
  - done pulses after edge E0+9 with pass=1, err_count=0, fail_vec=000.
- y1 stuck at 1:
  - Only vector 11 mismatches.
  - Result: err_count=1, fail_vec=3'b010, first_fail_idx=2'b11, pass=0.
- y0 driven as buffer of a instead of inverter, LOOPS=2:
  - All 8 samples mismatch.
  - Result: err_count=8, fail_vec=3'b001, first_fail_idx=2'b00, pass=0.
- Saturation, ERR_W=2, LOOPS=2, all outputs inverted:
  - Result: err_count=3 (saturated), fail_vec=3'b111, pass=0.
- start pulsed again at E0+3:
  - It is ignored; the sequence and completion time are unchanged.
- Reset mid-run:
  - Assert rst_n=0 between E0+5 and E0+6: all outputs are 0 immediately and no done follows.
  - A new start runs again from vector 00.
- start held high continuously with a correct gate model:
  - A new run is accepted in the done cycle and results clear; pass reads 0 during the new run.
  - The next done arrives 4·SETTLE_CYCLES·LOOPS+2 cycles later.

Source files
------------

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: sweeps {a,b} through all four vectors, checks y0..y2 against
// NOT/NAND/NOR and reports pass, a saturating error count, sticky per-output flags and the first bad vector.
module gate_truth_table_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int LOOPS = 1,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y0,
  input  logic             y1,
  input  logic             y2,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [2:0]       fail_vec,
  output logic [1:0]       first_fail_idx
);
  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  state_t state;
  logic [3:0] settle;
  logic [7:0] loop;
  logic [2:0] mism;
  logic sample, last;
  // {a,b} doubles as the vector index
  assign mism = {y2, y1, y0} ^ {~(a | b), ~(a & b), ~a};
  assign sample = settle == 4'(SETTLE_CYCLES - 1);
  assign last = {a, b} == 2'b11 && loop == 8'(LOOPS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      {a, b} <= 2'b00;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      err_count <= '0;
      fail_vec <= '0;
      first_fail_idx <= '0;
      settle <= '0;
      loop <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= RUN;
          {a, b} <= 2'b00;
          busy <= 1'b1;
          pass <= 1'b0;
          err_count <= '0;
          fail_vec <= '0;
          first_fail_idx <= '0;
          settle <= '0;
          loop <= '0;
        end
        RUN: if (!sample) settle <= settle + 4'd1;
        else begin
          settle <= '0;
          fail_vec <= fail_vec | mism;
          if (|mism && err_count != ERR_MAX) err_count <= err_count + ERR_W'(1);
          // a saturating count never returns to zero, so zero means no earlier failure
          if (|mism && err_count == '0) first_fail_idx <= {a, b};
          {a, b} <= last ? 2'b00 : {a, b} + 2'd1;
          if ({a, b} == 2'b11) loop <= loop + 8'd1;
          if (last) state <= FINISH;
        end
        FINISH: begin
          busy <= 1'b0;
          pass <= err_count == '0;
          done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: faulty-gate models drive three checker instances; a scoreboard
// queue holds expected results pushed at start and popped when done pulses.
module tb_gate_truth_table_checker;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  localparam int S [3] = '{2, 3, 3};
  localparam int L [3] = '{1, 2, 2};

  logic [2:0] start = '0, a, b, busy, done, pass;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [7:0] err [3];
  logic [2:0] fv [3];
  logic [1:0] ffi [3];
  logic [2:0] y [3];
  int mode [3] = '{0, 0, 0};
  int n_chk = 0, n_fail = 0, cyc = 0;

  assign err[0] = err0;
  assign err[1] = err1;
  assign err[2] = {6'b0, err2};

  // gate unit model with injectable faults, returns {y2,y1,y0}
  function automatic logic [2:0] gate(int m, logic ai, logic bi);
    logic [2:0] r;
    r = {~(ai | bi), ~(ai & bi), ~ai};
    case (m)
      1: r[1] = 1'b1;
      2: r[0] = ai;
      3: r = ~r;
      4: r[0] = 1'b0;
      5: r[2] = 1'b1;
      default: ;
    endcase
    return r;
  endfunction

  assign y[0] = gate(mode[0], a[0], b[0]);
  assign y[1] = gate(mode[1], a[1], b[1]);
  assign y[2] = gate(mode[2], a[2], b[2]);

  gate_truth_table_checker #(.SETTLE_CYCLES(2), .LOOPS(1), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .a(a[0]), .b(b[0]),
    .y0(y[0][0]), .y1(y[0][1]), .y2(y[0][2]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_count(err0), .fail_vec(fv[0]), .first_fail_idx(ffi[0]));
  gate_truth_table_checker #(.SETTLE_CYCLES(3), .LOOPS(2), .ERR_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .a(a[1]), .b(b[1]),
    .y0(y[1][0]), .y1(y[1][1]), .y2(y[1][2]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_count(err1), .fail_vec(fv[1]), .first_fail_idx(ffi[1]));
  gate_truth_table_checker #(.SETTLE_CYCLES(3), .LOOPS(2), .ERR_W(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .a(a[2]), .b(b[2]),
    .y0(y[2][0]), .y1(y[2][1]), .y2(y[2][2]), .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .err_count(err2), .fail_vec(fv[2]), .first_fail_idx(ffi[2]));

  typedef struct {
    int dut;
    int mode;
    logic glitch;
    logic [7:0] err;
    logic [2:0] fv;
    logic [1:0] ffi;
    logic pass;
  } vec_t;

  typedef struct {
    int dut;
    int done_cyc;
    logic [7:0] err;
    logic [2:0] fv;
    logic [1:0] ffi;
    logic pass;
  } exp_t;

  exp_t q[$];
  vec_t tbl [10];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  always @(negedge clk)
    for (int i = 0; i < 3; i++)
      if (done[i]) begin
        if (q.size() == 0 || q[0].dut != i) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: dut %0d pulsed done at cycle %0d with no run pending", i, cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          check($sformatf("done_cycle[%0d]", i), cyc, e.done_cyc);
          check($sformatf("err_count[%0d]", i), err[i], e.err);
          check($sformatf("fail_vec[%0d]", i), fv[i], e.fv);
          check($sformatf("first_fail_idx[%0d]", i), ffi[i], e.ffi);
          check($sformatf("pass[%0d]", i), pass[i], e.pass);
          check($sformatf("busy_at_done[%0d]", i), busy[i], 0);
        end
      end

  task automatic push_exp(int d, int done_cyc, vec_t v);
    exp_t e;
    e.dut = d;
    e.done_cyc = done_cyc;
    e.err = v.err;
    e.fv = v.fv;
    e.ffi = v.ffi;
    e.pass = v.pass;
    q.push_back(e);
  endtask

  task automatic drain(string name);
    repeat (3) @(negedge clk);
    check(name, q.size(), 0);
    q.delete();
  endtask

  task automatic run(vec_t v);
    int d, e0, n;
    logic [1:0] exp_ab;
    d = v.dut;
    n = 4 * S[d] * L[d];
    mode[d] = v.mode;
    @(negedge clk);
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    e0 = cyc;
    push_exp(d, e0 + n + 1, v);
    for (int t = 0; t <= n; t++) begin
      exp_ab = t < n ? 2'((t / S[d]) % 4) : 2'b00;
      check($sformatf("ab[%0d]@%0d", d, t), {a[d], b[d]}, exp_ab);
      check($sformatf("busy[%0d]@%0d", d, t), busy[d], 1);
      check($sformatf("pass_in_run[%0d]@%0d", d, t), pass[d], 0);
      if (v.glitch && t == 2) start[d] = 1'b1;
      if (t == 3) start[d] = 1'b0;
      @(negedge clk);
    end
    drain($sformatf("run_completed[%0d]", d));
  endtask

  initial begin
    int e0;
    vec_t ok0;
    tbl = '{
      '{0, 0, 1'b0, 8'd0, 3'b000, 2'b00, 1'b1},
      '{0, 1, 1'b0, 8'd1, 3'b010, 2'b11, 1'b0},
      '{0, 5, 1'b1, 8'd3, 3'b100, 2'b01, 1'b0},
      '{0, 3, 1'b0, 8'd4, 3'b111, 2'b00, 1'b0},
      '{1, 2, 1'b0, 8'd8, 3'b001, 2'b00, 1'b0},
      '{1, 0, 1'b1, 8'd0, 3'b000, 2'b00, 1'b1},
      '{1, 4, 1'b0, 8'd4, 3'b001, 2'b00, 1'b0},
      '{2, 3, 1'b0, 8'd3, 3'b111, 2'b00, 1'b0},
      '{2, 1, 1'b0, 8'd2, 3'b010, 2'b11, 1'b0},
      '{2, 5, 1'b0, 8'd3, 3'b100, 2'b01, 1'b0}
    };
    ok0 = tbl[0];
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("reset_outputs[%0d]", i),
            {a[i], b[i], busy[i], done[i], pass[i], err[i], fv[i], ffi[i]}, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) run(tbl[k]);

    // abort a failing run after two samples; nothing must survive and no done may follow
    mode[0] = 3;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    e0 = cyc;
    while (cyc < e0 + 5) @(negedge clk);
    check("pre_reset_err", err[0], 2);
    check("pre_reset_fv", fv[0], 3'b111);
    check("pre_reset_ab", {a[0], b[0]}, 2'b10);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs",
             {a[0], b[0], busy[0], done[0], pass[0], err[0], fv[0], ffi[0]}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("no_done_after_abort_pending", q.size(), 0);
    run(ok0);

    // start held high: rerun accepted in the done cycle
    mode[0] = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    e0 = cyc;
    push_exp(0, e0 + 9, ok0);
    push_exp(0, e0 + 19, ok0);
    while (cyc < e0 + 10) @(negedge clk);
    check("rerun_busy", busy[0], 1);
    check("rerun_pass_cleared", pass[0], 0);
    check("rerun_ab", {a[0], b[0]}, 2'b00);
    while (cyc < e0 + 19) @(negedge clk);
    start[0] = 1'b0;
    drain("held_start_runs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
